// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared types and field layout for the firebird7 IJTAG data-override TDR.
// The shift register is {select, mode, data[WIDTH-1:0]}.
package firebird7_in_gate1_tessent_tdr_pkg;

    localparam int DEF_WIDTH = 19;
    localparam int SEL_BIT   = DEF_WIDTH + 1;
    localparam int MODE_BIT  = DEF_WIDTH;

    typedef enum logic {
        MODE_STICKY = 1'b0,
        MODE_TIMED  = 1'b1
    } mode_e;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_if.sv
// IJTAG access signals plus the override bus toward the downstream data mux.
interface firebird7_in_gate1_tessent_tdr_data_ctl_if #(
    parameter int WIDTH = 19
);
    logic             ijtag_sel;
    logic             ijtag_ce;
    logic             ijtag_se;
    logic             ijtag_ue;
    logic             ijtag_si;
    logic             ijtag_so;
    logic [WIDTH-1:0] capture_data_in;
    logic [WIDTH-1:0] ijtag_data_out;
    logic             ijtag_select;

    modport master (
        output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
        input  ijtag_so, ijtag_data_out, ijtag_select
    );

    modport slave (
        input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
        output ijtag_so, ijtag_data_out, ijtag_select
    );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_hold_cnt.sv
// Timed-override hold counter: loads on update, counts down, flags the 1->0 step.
module firebird7_in_gate1_tessent_tdr_hold_cnt #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic load,
    input  logic arm,
    output logic expire
);
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset)
            hold_cnt <= '0;
        else if (load)
            hold_cnt <= arm ? CNT_W'(HOLD_CYCLES) : '0;
        else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - CNT_W'(1);
    end

    // An update in the same cycle wins over expiry so a reload never drops select.
    assign expire = !load && (hold_cnt == CNT_W'(1));

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl.sv
// IJTAG TDR driving the 19-bit functional/override mux, with sticky or timed select.
module firebird7_in_gate1_tessent_tdr_data_ctl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    firebird7_in_gate1_tessent_tdr_data_ctl_if.slave tdr
);
    localparam int SEL_B  = WIDTH + 1;
    localparam int MODE_B = WIDTH;

    logic [WIDTH+1:0] sr;
    logic [WIDTH-1:0] data_q;
    logic             sel_q;
    mode_e            mode_q;

    logic do_capture, do_shift, do_update, arm, expire;

    assign do_capture = tdr.ijtag_sel & tdr.ijtag_ce;
    assign do_shift   = tdr.ijtag_sel & tdr.ijtag_se & ~tdr.ijtag_ce;
    assign do_update  = tdr.ijtag_sel & tdr.ijtag_ue;
    assign arm        = sr[SEL_B] & sr[MODE_B];

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset)
            sr <= '0;
        else if (do_capture)
            sr <= {sel_q, mode_q, tdr.capture_data_in};
        else if (do_shift)
            sr <= {tdr.ijtag_si, sr[WIDTH+1:1]};
    end

    // Update samples the pre-edge sr, so a same-cycle capture/shift cannot leak in.
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            data_q <= '0;
            sel_q  <= 1'b0;
            mode_q <= MODE_STICKY;
        end else if (do_update) begin
            data_q <= sr[WIDTH-1:0];
            sel_q  <= sr[SEL_B];
            mode_q <= mode_e'(sr[MODE_B]);
        end else if (expire) begin
            sel_q  <= 1'b0;
        end
    end

    firebird7_in_gate1_tessent_tdr_hold_cnt #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_cnt (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .load        (do_update),
        .arm         (arm),
        .expire      (expire)
    );

    assign tdr.ijtag_so       = sr[0];
    assign tdr.ijtag_data_out = data_q;
    assign tdr.ijtag_select   = sel_q;

endmodule
